// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle HI/LO multiply/accumulate sequencer
module mul_sequencer #(
    parameter int PP_BITS = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] Rs,
    input  logic [31:0] Rt,
    input  logic        MtHi,
    input  logic        MtLo,
    input  logic        ReadHi,
    input  logic        ReadLo,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic [31:0] MulResult,
    output logic        MulValid
);

    localparam int N_ITER = 32 / PP_BITS;
    localparam int CW     = $clog2(N_ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_ACC} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] iter_cnt;
    logic [2:0]    op_q;
    logic          neg_q;
    logic [63:0]   mcand;
    logic [32:0]   mplier;
    logic [63:0]   psum;

    logic          is_signed, op_legal, accept;
    logic [32:0]   rs_ext, rt_ext, rs_mag, rt_mag;
    logic [63:0]   pp_term, product, hilo;

    assign is_signed = (Op == 3'd0) || (Op == 3'd2) || (Op == 3'd4) || (Op == 3'd6);
    assign op_legal  = (Op != 3'd7);
    assign accept    = Start && !Busy && op_legal;

    // 33-bit magnitudes keep -2^31 exact.
    assign rs_ext = {is_signed & Rs[31], Rs};
    assign rt_ext = {is_signed & Rt[31], Rt};
    assign rs_mag = rs_ext[32] ? -rs_ext : rs_ext;
    assign rt_mag = rt_ext[32] ? -rt_ext : rt_ext;

    assign pp_term = mcand * {{(64-PP_BITS){1'b0}}, mplier[PP_BITS-1:0]};
    assign product = neg_q ? -psum : psum;
    assign hilo    = {Hi, Lo};

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        Busy      = (state != S_IDLE);
        Stall     = Busy && (Start || MtHi || MtLo || ReadHi || ReadLo);
        case (state)
            S_IDLE: if (accept) state_nxt = S_ITER;
            S_ITER: if (iter_cnt == CW'(N_ITER - 1)) state_nxt = S_ACC;
            S_ACC:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Hi        <= '0;
            Lo        <= '0;
            MulResult <= '0;
            MulValid  <= 1'b0;
            iter_cnt  <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            psum      <= '0;
        end else begin
            MulValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Mt writes land before a same-cycle Start so MADD/MSUB see them.
                    if (MtHi) Hi <= Rs;
                    if (MtLo) Lo <= Rs;
                    if (accept) begin
                        op_q     <= Op;
                        neg_q    <= is_signed & (Rs[31] ^ Rt[31]);
                        mcand    <= {31'b0, rs_mag};
                        mplier   <= rt_mag;
                        psum     <= '0;
                        iter_cnt <= '0;
                    end
                end
                S_ITER: begin
                    psum     <= psum + pp_term;
                    mcand    <= mcand << PP_BITS;
                    mplier   <= mplier >> PP_BITS;
                    iter_cnt <= iter_cnt + CW'(1);
                end
                S_ACC: begin
                    iter_cnt <= '0;
                    case (op_q)
                        3'd0, 3'd1: {Hi, Lo} <= product;
                        3'd2, 3'd3: {Hi, Lo} <= hilo + product;
                        3'd4, 3'd5: {Hi, Lo} <= hilo - product;
                        default: begin
                            MulResult <= product[31:0];
                            MulValid  <= 1'b1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    illegal_op_a: assert property (@(posedge Clock) disable iff (Reset)
        !(Start && !Busy && Op == 3'd7));

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - scoreboard bench for mul_sequencer
module tb_mul_sequencer;

    logic        Clock = 1'b0;
    logic        Reset, Start, MtHi, MtLo, ReadHi, ReadLo;
    logic [2:0]  Op;
    logic [31:0] Rs, Rt;
    logic        Busy, Stall, MulValid;
    logic [31:0] Hi, Lo, MulResult;

    typedef struct {
        logic        is_mul;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] mr;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic busy_q = 1'b0;
    logic rst_q  = 1'b0;

    mul_sequencer #(.PP_BITS(8)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .Rs(Rs), .Rt(Rt),
        .MtHi(MtHi), .MtLo(MtLo), .ReadHi(ReadHi), .ReadLo(ReadLo),
        .Busy(Busy), .Stall(Stall), .Hi(Hi), .Lo(Lo),
        .MulResult(MulResult), .MulValid(MulValid)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: completion is the cycle Busy falls without a reset having caused it.
    always @(negedge Clock) begin
        if (busy_q && !Busy && !rst_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("hi", Hi, e.hi);
                check("lo", Lo, e.lo);
                check("mulvalid", {31'b0, MulValid}, {31'b0, e.is_mul});
                if (e.is_mul) check("mulresult", MulResult, e.mr);
            end
        end else if (MulValid) begin
            check("stray_mulvalid", {31'b0, MulValid}, 32'd0);
        end
        busy_q <= Busy;
        rst_q  <= Reset;
    end

    // Drives a Start (optionally with Mt) and holds it while stalled; returns edges taken.
    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic mthi, input logic mtlo, input logic push,
                         input logic [31:0] eh, input logic [31:0] el, input logic [31:0] em,
                         output int n);
        logic st;
        Start = 1'b1; Op = op; Rs = rs; Rt = rt; MtHi = mthi; MtLo = mtlo;
        if (push) exp_q.push_back('{is_mul: (op == 3'd6), hi: eh, lo: el, mr: em});
        n = 0;
        do begin
            @(negedge Clock); st = Stall;
            @(posedge Clock); #1; n++;
        end while (st && n < 30);
        if (st) check("issue_timeout", 32'd1, 32'd0);
        Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 30) begin @(posedge Clock); #1; n++; end
        if (Busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic mt(input logic hi, input logic lo, input logic [31:0] v);
        MtHi = hi; MtLo = lo; Rs = v;
        @(posedge Clock); #1;
        MtHi = 1'b0; MtLo = 1'b0;
    endtask

    initial begin
        int n, cnt;
        Reset = 1'b1; Start = 0; Op = 0; Rs = 0; Rt = 0;
        MtHi = 0; MtLo = 0; ReadHi = 0; ReadLo = 0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        check("rst_hi", Hi, 32'd0);
        check("rst_lo", Lo, 32'd0);
        check("rst_mulresult", MulResult, 32'd0);
        check("rst_mulvalid", {31'b0, MulValid}, 32'd0);
        ReadHi = 1'b1;
        #1 check("idle_read_stall", {31'b0, Stall}, 32'd0);
        @(posedge Clock); #1 ReadHi = 1'b0;

        // MULTU max * max, Busy length
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 32'hFFFFFFFE, 32'h00000001, 0, n);
        cnt = 0;
        while (Busy && cnt < 20) begin cnt++; @(posedge Clock); #1; end
        check("busy_cycles", cnt, 32'd5);

        // Signed MULT
        issue(3'd0, 32'hFFFFFFFD, 32'd7, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, n);
        wait_idle();
        issue(3'd0, 32'h80000000, 32'h80000000, 0, 0, 1, 32'h40000000, 32'h0, 0, n);
        wait_idle();

        // MTHI/MTLO then MADD, MSUB, and Start with same-cycle MTLO
        mt(1, 0, 32'd0);
        mt(0, 1, 32'd10);
        check("mt_hi", Hi, 32'd0);
        check("mt_lo", Lo, 32'd10);
        issue(3'd2, 32'd2, 32'd3, 0, 0, 1, 32'd0, 32'd16, 0, n);
        wait_idle();
        issue(3'd4, 32'd5, 32'd4, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, 0, n);
        wait_idle();
        issue(3'd3, 32'd5, 32'd2, 0, 1, 1, 32'hFFFFFFFF, 32'h0000000F, 0, n);
        wait_idle();

        // ReadLo stalls until the product lands
        issue(3'd0, 32'd6, 32'd7, 0, 0, 1, 32'd0, 32'h2A, 0, n);
        @(posedge Clock); #1 ReadLo = 1'b1;
        cnt = 0;
        @(negedge Clock);
        while (Stall && cnt < 20) begin cnt++; @(negedge Clock); end
        check("readlo_stall_cycles", cnt, 32'd4);
        check("readlo_value", Lo, 32'h2A);
        @(posedge Clock); #1 ReadLo = 1'b0;

        // Start held during Busy executes afterward
        issue(3'd1, 32'h00010000, 32'h00010000, 0, 0, 1, 32'd1, 32'd0, 0, n);
        issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 32'd0, 32'd1, 0, n);
        check("held_start_edges", n, 32'd6);
        wait_idle();

        // MUL: pulse, HI/LO untouched
        issue(3'd6, 32'h00010000, 32'h00010003, 0, 0, 1, 32'd0, 32'd1, 32'h00030000, n);
        wait_idle();
        @(posedge Clock); #1;
        check("mulvalid_width", {31'b0, MulValid}, 32'd0);
        issue(3'd6, 32'hFFFFFFFE, 32'd3, 0, 0, 1, 32'd0, 32'd1, 32'hFFFFFFFA, n);
        wait_idle();

        // Reset in second ITER cycle aborts the op
        issue(3'd3, 32'd7, 32'd9, 0, 0, 0, 0, 0, 0, n);
        @(posedge Clock); #1 Reset = 1'b1;
        @(posedge Clock); #1 Reset = 1'b0;
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_hi", Hi, 32'd0);
        check("abort_lo", Lo, 32'd0);
        issue(3'd0, 32'd3, 32'hFFFFFFFB, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, n);
        check("post_reset_accept", n, 32'd1);
        wait_idle();
        repeat (8) @(posedge Clock);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
